// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer allocation controller: tail allocation, out-of-order completion,
// in-order commit at the head, and mispredict flush with a one-cycle recovery bubble.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   RUN      | normal allocate / complete / commit operation
//   RECOVER  | one cycle after an accepted flush; allocation is blocked
module rob_alloc_ctrl #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    output logic             full_o,
    output logic [TAG_W-1:0] alloc_tag_o,
    output logic             empty_o,
    output logic [TAG_W:0]   count_o,
    input  logic             complete_valid_i,
    input  logic [TAG_W-1:0] complete_tag_i,
    input  logic             commit_ready_i,
    output logic             commit_o,
    output logic [TAG_W-1:0] commit_tag_o,
    input  logic             flush_i,
    input  logic [TAG_W-1:0] flush_tag_i
);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    localparam logic [TAG_W:0]   DEPTH_CNT = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W-1:0] ONE       = TAG_W'(1);

    state_t           state;
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] done;

    logic             push_acc;
    logic             flush_acc;
    logic [TAG_W-1:0] head_nxt;
    logic [TAG_W-1:0] tail_nxt;
    logic [TAG_W-1:0] flush_age;
    logic [TAG_W-1:0] ent_age;
    logic [DEPTH-1:0] valid_nxt;
    logic [DEPTH-1:0] done_nxt;
    logic [TAG_W:0]   count_nxt;

    // Gated by rst_n so a flush request held during reset cannot show as full.
    assign full_o       = rst_n && ((count == DEPTH_CNT) || (state == ST_RECOVER) || flush_i);
    assign push_acc     = push_i && !full_o;
    assign commit_o     = valid[head] && done[head] && commit_ready_i;
    assign commit_tag_o = head;
    assign alloc_tag_o  = tail;
    assign count_o      = count;
    assign empty_o      = (count == '0);
    assign flush_acc    = flush_i && (state == ST_RUN) && valid[flush_tag_i];

    always_comb begin
        valid_nxt = valid;
        done_nxt  = done;
        head_nxt  = head;
        tail_nxt  = tail;
        flush_age = flush_tag_i - head;
        ent_age   = '0;

        if (complete_valid_i && valid[complete_tag_i]) begin
            done_nxt[complete_tag_i] = 1'b1;
        end

        if (commit_o) begin
            valid_nxt[head] = 1'b0;
            done_nxt[head]  = 1'b0;
            head_nxt        = head + ONE;
        end

        if (push_acc) begin
            valid_nxt[tail] = 1'b1;
            done_nxt[tail]  = 1'b0;
            tail_nxt        = tail + ONE;
        end

        // Age is distance from the current head, so "younger" survives wrap-around.
        if (flush_acc) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_age = TAG_W'(i) - head;
                if (ent_age > flush_age) begin
                    valid_nxt[i] = 1'b0;
                    done_nxt[i]  = 1'b0;
                end
            end
            tail_nxt = flush_tag_i + ONE;
        end

        count_nxt = (&valid_nxt) ? DEPTH_CNT : {1'b0, tail_nxt - head_nxt};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            done  <= '0;
        end else begin
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
            valid <= valid_nxt;
            done  <= done_nxt;
            case (state)
                ST_RUN:     state <= flush_acc ? ST_RECOVER : ST_RUN;
                ST_RECOVER: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Bench for rob_alloc_ctrl: cycle-by-cycle vector table checked through a scoreboard,
// plus a hand-written mid-cycle asynchronous reset sequence.
module tb_rob_alloc_ctrl;

    localparam int DEPTH = 16;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             push_i = 1'b0;
    logic             full_o;
    logic [TAG_W-1:0] alloc_tag_o;
    logic             empty_o;
    logic [TAG_W:0]   count_o;
    logic             complete_valid_i = 1'b0;
    logic [TAG_W-1:0] complete_tag_i = '0;
    logic             commit_ready_i = 1'b0;
    logic             commit_o;
    logic [TAG_W-1:0] commit_tag_o;
    logic             flush_i = 1'b0;
    logic [TAG_W-1:0] flush_tag_i = '0;

    rob_alloc_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .push_i           (push_i),
        .full_o           (full_o),
        .alloc_tag_o      (alloc_tag_o),
        .empty_o          (empty_o),
        .count_o          (count_o),
        .complete_valid_i (complete_valid_i),
        .complete_tag_i   (complete_tag_i),
        .commit_ready_i   (commit_ready_i),
        .commit_o         (commit_o),
        .commit_tag_o     (commit_tag_o),
        .flush_i          (flush_i),
        .flush_tag_i      (flush_tag_i)
    );

    always #5 clk = ~clk;

    // Each vector: inputs for one cycle and the outputs expected mid-cycle,
    // i.e. registered state from previous cycles plus combinational effect of these inputs.
    typedef struct {
        int rst;
        int push; int cv; int ctag; int cr; int fl; int ftag;
        int full; int alloc; int empty; int count; int commit; int ctag_o;
    } vec_t;

    typedef struct {
        int full; int alloc; int empty; int count; int commit; int ctag_o;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input int rst, input int push, input int cv, input int ctag,
                       input int cr, input int fl, input int ftag,
                       input int full, input int alloc, input int empty,
                       input int count, input int commit, input int ctag_o);
        vec_t v;
        v.rst = rst; v.push = push; v.cv = cv; v.ctag = ctag; v.cr = cr;
        v.fl = fl; v.ftag = ftag; v.full = full; v.alloc = alloc; v.empty = empty;
        v.count = count; v.commit = commit; v.ctag_o = ctag_o;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " full"},       32'(full_o),       0);
        chk({tag, " empty"},      32'(empty_o),      1);
        chk({tag, " count"},      32'(count_o),      0);
        chk({tag, " alloc_tag"},  32'(alloc_tag_o),  0);
        chk({tag, " commit"},     32'(commit_o),     0);
        chk({tag, " commit_tag"}, 32'(commit_tag_o), 0);
    endtask

    // Reset with push/flush held high to show they have no effect while in reset.
    task automatic do_reset();
        rst_n            = 1'b0;
        push_i           = 1'b1;
        flush_i          = 1'b1;
        flush_tag_i      = '0;
        complete_valid_i = 1'b0;
        commit_ready_i   = 1'b1;
        #1;
        chk_reset_outputs("in_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        push_i         = 1'b0;
        flush_i        = 1'b0;
        commit_ready_i = 1'b0;
        rst_n          = 1'b1;
    endtask

    task automatic build_table();
        // fill: 16 pushes, alloc tag wraps, 17th push ignored
        for (int k = 0; k < 16; k++) add(k == 0, 1,0,0,0,0,0, 0,k,(k == 0),k,0,0);
        add(0, 1,0,0,0,0,0, 1,0,0,16,0,0);
        add(0, 0,0,0,0,0,0, 1,0,0,16,0,0);

        // out-of-order completion, in-order commit
        add(1, 1,0,0,0,0,0, 0,0,1,0,0,0);
        add(0, 1,0,0,0,0,0, 0,1,0,1,0,0);
        add(0, 1,0,0,0,0,0, 0,2,0,2,0,0);
        add(0, 0,1,2,1,0,0, 0,3,0,3,0,0);
        add(0, 0,1,1,1,0,0, 0,3,0,3,0,0);
        add(0, 0,1,0,1,0,0, 0,3,0,3,0,0);
        add(0, 0,0,0,1,0,0, 0,3,0,3,1,0);
        add(0, 0,0,0,1,0,0, 0,3,0,2,1,1);
        add(0, 0,0,0,1,0,0, 0,3,0,1,1,2);
        add(0, 0,0,0,1,0,0, 0,3,1,0,0,3);

        // flush at tag 2 with tail 6; push in the flush cycle is blocked
        for (int k = 0; k < 6; k++) add(k == 0, 1,0,0,0,0,0, 0,k,(k == 0),k,0,0);
        add(0, 1,0,0,0,1,2, 1,6,0,6,0,0);
        add(0, 1,0,0,0,0,0, 1,3,0,3,0,0);
        add(0, 1,0,0,0,0,0, 0,3,0,3,0,0);
        add(0, 0,0,0,0,0,0, 0,4,0,4,0,0);

        // wrap-around: drive head to 14, tail to 2, then push+commit together
        for (int k = 0; k < 14; k++)
            add(k == 0, 1,(k > 0),(k > 0) ? k-1 : 0,0,0,0, 0,k,(k == 0),k,0,0);
        add(0, 0,1,13,1,0,0, 0,14,0,14,1,0);
        for (int j = 1; j < 14; j++) add(0, 0,0,0,1,0,0, 0,14,0,14-j,1,j);
        for (int j = 0; j < 4; j++)
            add(0, 1,(j == 1),14,0,0,0, 0,(14+j) % 16,(j == 0),j,0,14);
        add(0, 1,0,0,1,0,0, 0,2,0,4,1,14);
        add(0, 0,0,0,0,0,0, 0,3,0,4,0,15);

        // backpressure: head done, commit_ready low for 3 cycles
        add(1, 1,0,0,0,0,0, 0,0,1,0,0,0);
        add(0, 0,1,0,0,0,0, 0,1,0,1,0,0);
        for (int j = 0; j < 3; j++) add(0, 0,0,0,0,0,0, 0,1,0,1,0,0);
        add(0, 0,0,0,1,0,0, 0,1,0,1,1,0);
        add(0, 0,0,0,1,0,0, 0,1,1,0,0,1);

        // flush + commit + completion of a squashed entry in one cycle
        for (int k = 0; k < 4; k++) add(k == 0, 1,0,0,0,0,0, 0,k,(k == 0),k,0,0);
        add(0, 0,1,0,0,0,0, 0,4,0,4,0,0);
        add(0, 0,1,3,1,1,1, 1,4,0,4,1,0);
        add(0, 0,0,0,0,0,0, 1,2,0,1,0,1);
        add(0, 0,0,0,0,0,0, 0,2,0,1,0,1);
        add(0, 0,1,1,0,0,0, 0,2,0,1,0,1);
        add(0, 0,0,0,1,0,0, 0,2,0,1,1,1);
        add(0, 0,0,0,1,0,0, 0,2,1,0,0,2);

        // flush to an invalid tag is ignored (no RECOVER cycle, tail unchanged)
        add(1, 1,0,0,0,0,0, 0,0,1,0,0,0);
        add(0, 1,0,0,0,0,0, 0,1,0,1,0,0);
        add(0, 0,0,0,0,1,5, 1,2,0,2,0,0);
        add(0, 0,0,0,0,0,0, 0,2,0,2,0,0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        build_table();

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst != 0) do_reset();
            @(posedge clk);
            #1;
            push_i           = (vecs[i].push != 0);
            complete_valid_i = (vecs[i].cv != 0);
            complete_tag_i   = TAG_W'(vecs[i].ctag);
            commit_ready_i   = (vecs[i].cr != 0);
            flush_i          = (vecs[i].fl != 0);
            flush_tag_i      = TAG_W'(vecs[i].ftag);
            e.full   = vecs[i].full;   e.alloc  = vecs[i].alloc;
            e.empty  = vecs[i].empty;  e.count  = vecs[i].count;
            e.commit = vecs[i].commit; e.ctag_o = vecs[i].ctag_o;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("v%0d full", i),       32'(full_o),       e.full);
            chk($sformatf("v%0d alloc_tag", i),  32'(alloc_tag_o),  e.alloc);
            chk($sformatf("v%0d empty", i),      32'(empty_o),      e.empty);
            chk($sformatf("v%0d count", i),      32'(count_o),      e.count);
            chk($sformatf("v%0d commit", i),     32'(commit_o),     e.commit);
            chk($sformatf("v%0d commit_tag", i), 32'(commit_tag_o), e.ctag_o);
        end

        // Mid-cycle asynchronous reset with 5 entries in flight.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            push_i = 1'b1;
            complete_valid_i = (k > 0);
            complete_tag_i   = TAG_W'(k > 0 ? k - 1 : 0);
        end
        @(posedge clk);
        #1;
        push_i           = 1'b0;
        complete_valid_i = 1'b0;
        commit_ready_i   = 1'b0;
        @(negedge clk);
        chk("pre_async count", 32'(count_o), 5);
        chk("pre_async alloc_tag", 32'(alloc_tag_o), 5);
        #2;
        commit_ready_i = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        chk_reset_outputs("async_reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_async commit", 32'(commit_o), 0);
        chk("post_async count", 32'(count_o), 0);
        commit_ready_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rob_alloc_ctrl.md
ROB_ALLOC_CTRL -- requirements
Module: rob_alloc_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning the number of ROB entries (a power of two).
REQ-002 SHALL have parameter TAG_W, default 4, meaning the tag width, equal to log2(DEPTH).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port push_i, input, 1, allocate the entry at alloc_tag_o this cycle.
REQ-006 SHALL have port full_o, output, 1, allocation not permitted this cycle.
REQ-007 SHALL have port alloc_tag_o, output, TAG_W, the tag the next push receives (tail pointer).
REQ-008 SHALL have port empty_o, output, 1, no valid entries.
REQ-009 SHALL have port count_o, output, TAG_W+1, number of valid entries, 0..DEPTH.
REQ-010 SHALL have ports complete_valid_i (input, 1) and complete_tag_i (input, TAG_W), which mark an entry done.
REQ-011 SHALL have port commit_ready_i, input, 1, the retire stage accepts a commit.
REQ-012 SHALL have ports commit_o (output, 1) and commit_tag_o (output, TAG_W), which retire the head entry.
REQ-013 SHALL have ports flush_i (input, 1) and flush_tag_i (input, TAG_W), which mispredict-squash everything younger than flush_tag_i.

Function
REQ-014 SHALL keep head, tail (TAG_W each), count (TAG_W+1), and per-entry valid[DEPTH] and done[DEPTH] bits.
REQ-015 SHALL implement a 2-state FSM (RUN, RECOVER): RUN goes to RECOVER on an accepted flush; RECOVER always returns to RUN after 1 cycle.
REQ-016 SHALL drive full_o = (count == DEPTH) || (state == RECOVER) || flush_i, combinationally from registered state plus flush_i.
REQ-017 SHALL accept a push only when push_i && !full_o; accepted push sets valid[tail]=1 and done[tail]=0, and advances tail by 1 modulo DEPTH.
REQ-018 SHALL ignore push_i while full_o=1, with no state change.
REQ-019 SHALL, on complete_valid_i with valid[complete_tag_i]=1, set done[complete_tag_i]=1 at the next edge; completion to an invalid entry SHALL be ignored.
REQ-020 SHALL drive commit_o = valid[head] && done[head] && commit_ready_i (combinational) and commit_tag_o = head.
REQ-021 SHALL, on commit_o, clear valid[head] and advance head by 1 modulo DEPTH; at most one commit per cycle.
REQ-022 SHALL accept a flush only when flush_i && valid[flush_tag_i] and flush_tag_i != head-or-older; an invalid flush_tag_i SHALL be ignored.
REQ-023 SHALL, on an accepted flush, clear valid for all entries strictly younger than flush_tag_i up to tail-1, and set tail = flush_tag_i+1 modulo DEPTH.
REQ-024 SHALL compute count = ((tail_next - head_next) mod DEPTH), or DEPTH when all valid bits are set, so that count_o is consistent every cycle.
REQ-025 SHALL, when push and commit occur in the same cycle, apply both, leaving count unchanged.
REQ-026 SHALL, when flush and commit occur in the same cycle, apply both: head advances, and the flushed entry itself survives.
REQ-027 SHALL, when flush and completion target the same squashed entry in the same cycle, leave that entry invalid.
REQ-028 SHALL, when flush and push occur in the same cycle, block the push via full_o.
REQ-029 SHALL drive empty_o = (count == 0).

Reset
REQ-030 SHALL, while rst_n=0, asynchronously force head=0, tail=0, count=0, all valid/done bits=0, and state=RUN.
REQ-031 SHALL, during reset, output full_o=0, empty_o=1, count_o=0, alloc_tag_o=0, commit_o=0, and commit_tag_o=0.
REQ-032 SHALL, on reset asserted mid-operation, discard all in-flight entries with no commit emitted.

Verification
REQ-033 SHALL cover fill: 16 pushes from reset -> alloc_tag_o steps 0..15 then wraps to 0; full_o=1 and count_o=16 after the 16th push; a 17th push is ignored.
REQ-034 SHALL cover out-of-order completion: push 3, complete tags 2 then 1 then 0 -> commit_o only after tag 0 is done, then tags 0,1,2 commit on consecutive cycles with commit_ready_i=1.
REQ-035 SHALL cover flush: head=0, tail=6, flush_tag_i=2 -> tail=3, count_o=3, full_o=1 for the flush cycle plus 1 RECOVER cycle, then alloc_tag_o=3.
REQ-036 SHALL cover wrap-around with simultaneous push and commit: head=14, tail=2 (count 4) -> after push+commit, head=15, tail=3, count_o=4.
REQ-037 SHALL cover backpressure: head done with commit_ready_i=0 for 3 cycles -> commit_o=0 and head held; commit_o=1 in the cycle commit_ready_i rises.
REQ-038 SHALL cover async reset: rst_n dropped mid-cycle with count 5 -> outputs reach reset values before the next clock edge.
